// File: rtl/data_mem.sv
// Data memory for the RV32I data interface: one read and one write channel with
// byte/half/word access, zero-fill after reset, and sticky first-fault capture.
module data_mem #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rdy,
  input  logic        r_en,
  input  logic [31:0] r_addr,
  input  logic [1:0]  r_bmul,
  output logic [31:0] r_data,
  input  logic        w_en,
  input  logic [31:0] w_addr,
  input  logic [31:0] w_data,
  input  logic [1:0]  w_bmul,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] err_addr
);

  localparam int              AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0]     DEPTH_L  = 32'(DEPTH_WORDS);
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH_WORDS - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  typedef enum logic [1:0] {
    FLT_NONE  = 2'b00,
    FLT_ALIGN = 2'b01,
    FLT_RANGE = 2'b10,
    FLT_SIZE  = 2'b11
  } fault_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          rdy_q, rdy_d;
  logic [31:0]   r_data_q, r_data_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [31:0]   err_addr_q, err_addr_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          busy;
  fault_e        r_fault, w_fault;
  logic          r_ok, w_ok;
  logic [31:0]   rd_word, rd_shift;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_word;
  logic [3:0]    wr_be;

  // Busy (clearing) and reserved size share one code; range beats alignment.
  function automatic fault_e classify(input logic [31:0] addr, input logic [1:0] bmul,
                                      input logic is_busy);
    fault_e f;
    f = FLT_NONE;
    if (is_busy || bmul == 2'b11)
      f = FLT_SIZE;
    else if ({2'b00, addr[31:2]} >= DEPTH_L)
      f = FLT_RANGE;
    else if ((bmul == 2'b01 && addr[0]) || (bmul == 2'b10 && addr[1:0] != 2'b00))
      f = FLT_ALIGN;
    return f;
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    busy    = (state_q == ST_CLEAR);
    r_fault = r_en ? classify(r_addr, r_bmul, busy) : FLT_NONE;
    w_fault = w_en ? classify(w_addr, w_bmul, busy) : FLT_NONE;
    r_ok    = r_en && (r_fault == FLT_NONE);
    w_ok    = w_en && (w_fault == FLT_NONE);
  end

  // Read sees the array before this edge's write lands: read-before-write.
  always_comb begin
    rd_word  = mem[r_addr[AW+1:2]];
    rd_shift = rd_word >> {r_addr[1:0], 3'b000};
    r_data_d = r_data_q;
    if (r_ok) begin
      case (r_bmul)
        2'b00:   r_data_d = {24'h0, rd_shift[7:0]};
        2'b01:   r_data_d = {16'h0, rd_shift[15:0]};
        default: r_data_d = rd_word;
      endcase
    end
  end

  // Single write port shared by the clear sequencer and the write channel.
  always_comb begin
    wr_idx  = w_addr[AW+1:2];
    wr_word = w_data;
    wr_be   = 4'b0000;
    if (busy) begin
      wr_idx  = cnt_q;
      wr_word = '0;
      wr_be   = 4'b1111;
    end else if (w_ok) begin
      case (w_bmul)
        2'b00: begin
          wr_word = {4{w_data[7:0]}};
          wr_be   = 4'b0001 << w_addr[1:0];
        end
        2'b01: begin
          wr_word = {2{w_data[15:0]}};
          wr_be   = w_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: wr_be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    if (state_q == ST_CLEAR) begin
      if (cnt_q == LAST_IDX) begin
        state_d = ST_READY;
        rdy_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Only the first fault is recorded; a read fault wins over a write fault.
  always_comb begin
    err_d      = err_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    if (!err_q) begin
      if (r_fault != FLT_NONE) begin
        err_d      = 1'b1;
        err_code_d = r_fault;
        err_addr_d = r_addr;
      end else if (w_fault != FLT_NONE) begin
        err_d      = 1'b1;
        err_code_d = w_fault;
        err_addr_d = w_addr;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      rdy_q      <= 1'b0;
      r_data_q   <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdy_q      <= rdy_d;
      r_data_q   <= r_data_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
    end
  end

  // NOTE: the array has no reset; the clear sequencer zero-fills it instead,
  // which keeps it mappable onto RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_word[8*b +: 8];
    end
  end

  assign rdy      = rdy_q;
  assign r_data   = r_data_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_data_mem.sv
// Randomized plus directed bench for data_mem: a byte-addressed reference model
// feeds a read-result scoreboard that a separate monitor drains.
module tb_data_mem;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy;
  logic        r_en = 1'b0;
  logic [31:0] r_addr = '0;
  logic [1:0]  r_bmul = '0;
  logic [31:0] r_data;
  logic        w_en = 1'b0;
  logic [31:0] w_addr = '0;
  logic [31:0] w_data = '0;
  logic [1:0]  w_bmul = '0;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] err_addr;

  data_mem #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .r_en(r_en), .r_addr(r_addr), .r_bmul(r_bmul), .r_data(r_data),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_bmul(w_bmul),
    .err(err), .err_code(err_code), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int since;

  always @(posedge clk) cyc++;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) since <= 0;
    else        since <= since + 1;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0]  mem_m [DEPTH*4];
  logic [31:0] rdata_m;
  logic        err_m;
  logic [1:0]  code_m;
  logic [31:0] eaddr_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      check("r_data", r_data, e.data);
    end
  end

  function automatic logic [1:0] m_fault(input logic [31:0] addr, input logic [1:0] bmul,
                                         input logic is_busy);
    int unsigned size;
    size = 1 << bmul;
    if (is_busy || bmul == 2'd3) return 2'd3;
    if (addr / 4 >= DEPTH) return 2'd2;
    if (addr % size != 0) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH*4; i++) mem_m[i] = 8'h00;
    rdata_m = '0;
    err_m   = 1'b0;
    code_m  = '0;
    eaddr_m = '0;
  endtask

  task automatic issue(input logic re, input logic [31:0] ra, input logic [1:0] rb,
                       input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [1:0] wb);
    logic       is_busy;
    logic [1:0] rf, wf;
    logic [31:0] v;
    exp_t       e;
    @(negedge clk);
    r_en = re; r_addr = ra; r_bmul = rb;
    w_en = we; w_addr = wa; w_data = wd; w_bmul = wb;
    is_busy = (since < DEPTH);
    rf = re ? m_fault(ra, rb, is_busy) : 2'd0;
    wf = we ? m_fault(wa, wb, is_busy) : 2'd0;
    if (!err_m) begin
      if (rf != 0)      begin err_m = 1'b1; code_m = rf; eaddr_m = ra; end
      else if (wf != 0) begin err_m = 1'b1; code_m = wf; eaddr_m = wa; end
    end
    if (re && rf == 0) begin
      v = '0;
      for (int i = 0; i < (1 << rb); i++) v[8*i +: 8] = mem_m[int'(ra) + i];
      rdata_m = v;
    end
    if (re) begin
      e.due  = cyc + 1;
      e.data = rdata_m;
      exp_q.push_back(e);
    end
    if (we && wf == 0)
      for (int i = 0; i < (1 << wb); i++) mem_m[int'(wa) + i] = wd[8*i +: 8];
    @(posedge clk);
    #1;
    r_en = 1'b0;
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] b);
    issue(1'b1, a, b, 1'b0, '0, '0, 2'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] b);
    issue(1'b0, '0, 2'd0, 1'b1, a, d, b);
  endtask

  task automatic check_err(input string name);
    check({name, "_err"},      {31'd0, err}, {31'd0, err_m});
    check({name, "_err_code"}, {30'd0, err_code}, {30'd0, code_m});
    check({name, "_err_addr"}, err_addr, eaddr_m);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_rdy",      {31'd0, rdy}, 32'd0);
    check("rst_r_data",   r_data, 32'd0);
    check("rst_err",      {31'd0, err}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_check();
    for (int k = 0; k < DEPTH; k++) begin
      check("rdy_low_during_clear", {31'd0, rdy}, 32'd0);
      @(posedge clk);
      #1;
    end
    check("rdy_high_after_clear", {31'd0, rdy}, 32'd1);
  endtask

  task automatic wait_rdy();
    for (int i = 0; i < 4*DEPTH && !rdy; i++) begin
      @(posedge clk);
      #1;
    end
    check("wait_rdy", {31'd0, rdy}, 32'd1);
  endtask

  function automatic logic [31:0] rand_addr(input logic [1:0] b);
    int unsigned p;
    logic [31:0] a;
    p = $urandom_range(0, 99);
    a = $urandom_range(0, DEPTH*4 - 1);
    if (p < 1)       a = $urandom;
    else if (p >= 3 && b != 2'd3) a = a & ~((32'd1 << b) - 32'd1);
    return a;
  endfunction

  function automatic logic [1:0] rand_bmul();
    return ($urandom_range(0, 99) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic        re, we;
    logic [1:0]  rb, wb;
    logic [31:0] ra, wa;
    model_reset();

    // Run 1: clear timing, zero fill, sub-word access, same-word, sticky error.
    do_reset();
    clear_check();
    for (int a = 0; a < DEPTH; a++) rd(32'(a*4), 2'd2);

    wr(32'h8, 32'h11223344, 2'd2);
    wr(32'hA, 32'h000000AA, 2'd0);
    wr(32'h8, 32'h0000BEEF, 2'd1);
    rd(32'h8, 2'd2); check("word_0x8", r_data, 32'h11AABEEF);
    rd(32'hB, 2'd0); check("byte_0xB", r_data, 32'h00000011);
    rd(32'hA, 2'd1); check("half_0xA", r_data, 32'h000011AA);

    wr(32'h4, 32'h5, 2'd2);
    issue(1'b1, 32'h4, 2'd2, 1'b1, 32'h4, 32'h7, 2'd2);
    check("rbw_old", r_data, 32'h5);
    rd(32'h4, 2'd2); check("rbw_new", r_data, 32'h7);

    wr(32'h6, 32'h12345678, 2'd2);
    check("misalign_err", {31'd0, err}, 32'd1);
    check("misalign_code", {30'd0, err_code}, 32'd1);
    check("misalign_addr", err_addr, 32'h6);
    rd(32'h4, 2'd2); check("misalign_unchanged", r_data, 32'h7);
    rd(32'h40, 2'd2);
    check("sticky_code", {30'd0, err_code}, 32'd1);
    check("sticky_addr", err_addr, 32'h6);
    check("oob_r_data_held", r_data, 32'h7);

    // Run 2: reserved read size leaves r_data alone.
    do_reset();
    wait_rdy();
    wr(32'hC, 32'hCAFEF00D, 2'd2);
    rd(32'hC, 2'd2);
    check("no_err_yet", {31'd0, err}, 32'd0);
    rd(32'h10, 2'd3);
    check("reserved_r_data", r_data, 32'hCAFEF00D);
    check("reserved_code", {30'd0, err_code}, 32'd3);
    check("reserved_addr", err_addr, 32'h10);

    // Run 3: write on the final clear edge is refused.
    do_reset();
    repeat (DEPTH - 1) @(posedge clk);
    wr(32'h0, 32'hDEADBEEF, 2'd2);
    check("rdy_after_last_clear", {31'd0, rdy}, 32'd1);
    check("clear_write_code", {30'd0, err_code}, 32'd3);
    check("clear_write_addr", err_addr, 32'h0);
    rd(32'h0, 2'd2); check("clear_write_dropped", r_data, 32'h0);

    // Run 4: reset pulse mid-clear restarts the whole sequence.
    do_reset();
    wr(32'h10, 32'hDEAD, 2'd2);
    check_err("clear_fault");
    repeat (3) @(posedge clk);
    do_reset();
    clear_check();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      re = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      rb = rand_bmul();
      wb = rand_bmul();
      ra = rand_addr(rb);
      wa = ($urandom_range(0, 9) == 0) ? ra : rand_addr(wb);
      issue(re, ra, rb, we, wa, $urandom, wb);
    end
    check_err("random");
    for (int a = 0; a < DEPTH; a++) rd(32'(a*4), 2'd2);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
